// File: rtl/seg_scan_if.sv
// Signal bundle between the digit source and the 74HC595 scanner: eight digit
// codes in, serial chain controls and scan status out.
interface seg_scan_if;
  logic [3:0] bit_7;
  logic [3:0] bit_6;
  logic [3:0] bit_5;
  logic [3:0] bit_4;
  logic [3:0] bit_3;
  logic [3:0] bit_2;
  logic [3:0] bit_1;
  logic [3:0] bit_0;
  logic       ds;
  logic       shcp;
  logic       stcp;
  logic [2:0] digit_idx;
  logic       frame_done;

  modport master (
    output bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0,
    input  ds, shcp, stcp, digit_idx, frame_done
  );

  modport slave (
    input  bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0,
    output ds, shcp, stcp, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_595.sv
// Eight-digit common-anode scanner: decodes one digit at a time, shifts {seg, sel}
// MSB first into two cascaded 74HC595s, latches it, then dwells before the next digit.
module seg_scan_595 #(
  parameter int SCLK_DIV = 2,
  parameter int DWELL    = 1000
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam int CNT_MAX = (SCLK_DIV > DWELL) ? SCLK_DIV : DWELL;
  // The counter only ever holds 0 .. CNT_MAX-1.
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DWELL    = 3'd4
  } state_t;

  // Active-low segments {dp, g..a}; dp is never lit.
  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      4'd11:   seg_decode = 8'hBF;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       bit_cnt_r, bit_cnt_s;
  logic [15:0]      frame_r, frame_s;
  logic [2:0]       idx_r, idx_s;
  logic             ds_r, ds_s;
  logic             shcp_r, shcp_s;
  logic             stcp_r, stcp_s;
  logic             frame_done_r, frame_done_s;
  logic [3:0]       code_s;

  // Pick the digit code addressed by the current scan position.
  always_comb begin
    code_s = 4'd10;
    case (idx_r)
      3'd0:    code_s = bus.bit_0;
      3'd1:    code_s = bus.bit_1;
      3'd2:    code_s = bus.bit_2;
      3'd3:    code_s = bus.bit_3;
      3'd4:    code_s = bus.bit_4;
      3'd5:    code_s = bus.bit_5;
      3'd6:    code_s = bus.bit_6;
      3'd7:    code_s = bus.bit_7;
      default: code_s = 4'd10;
    endcase
  end

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + CNT_W'(1);
    bit_cnt_s = bit_cnt_r;
    frame_s   = frame_r;
    idx_s     = idx_r;
    ds_s      = ds_r;
    case (state_r)
      ST_LOAD: begin
        frame_s   = {seg_decode(code_s), 8'd1 << idx_r};
        bit_cnt_s = 4'd15;
        cnt_s     = CNT_W'(0);
        ds_s      = frame_s[15];
        state_s   = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (cnt_r == SHIFT_LAST) begin
          cnt_s   = CNT_W'(0);
          state_s = ST_SHIFT_HI;
        end else begin
          state_s = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (cnt_r != SHIFT_LAST) begin
          state_s = ST_SHIFT_HI;
        end else if (bit_cnt_r == 4'd0) begin
          cnt_s   = CNT_W'(0);
          state_s = ST_LATCH;
        end else begin
          cnt_s     = CNT_W'(0);
          bit_cnt_s = bit_cnt_r - 4'd1;
          ds_s      = frame_r[bit_cnt_s];
          state_s   = ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        if (cnt_r == SHIFT_LAST) begin
          cnt_s   = CNT_W'(0);
          state_s = ST_DWELL;
        end else begin
          state_s = ST_LATCH;
        end
      end
      ST_DWELL: begin
        if (cnt_r == DWELL_LAST) begin
          cnt_s   = CNT_W'(0);
          idx_s   = idx_r + 3'd1;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_DWELL;
        end
      end
      default: begin
        cnt_s   = CNT_W'(0);
        state_s = ST_LOAD;
      end
    endcase
    shcp_s       = (state_s == ST_SHIFT_HI);
    stcp_s       = (state_s == ST_LATCH);
    // Pulse lands on the final latch cycle, while stcp is still high.
    frame_done_s = (state_s == ST_LATCH) && (cnt_s == SHIFT_LAST);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_LOAD;
      cnt_r        <= CNT_W'(0);
      bit_cnt_r    <= 4'd0;
      frame_r      <= 16'd0;
      idx_r        <= 3'd0;
      ds_r         <= 1'b0;
      shcp_r       <= 1'b0;
      stcp_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      frame_r      <= frame_s;
      idx_r        <= idx_s;
      ds_r         <= ds_s;
      shcp_r       <= shcp_s;
      stcp_r       <= stcp_s;
      frame_done_r <= frame_done_s;
    end
  end

  assign bus.ds         = ds_r;
  assign bus.shcp       = shcp_r;
  assign bus.stcp       = stcp_r;
  assign bus.digit_idx  = idx_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_595.sv
// Bench for seg_scan_595: a negedge monitor rebuilds each shifted frame and checks it
// against a scoreboard filled from a code/frame table plus reset and input-stability sequences.
module tb_seg_scan_595;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] frame;
    logic [2:0]  idx;
  } sb_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sb_t         sb_q[$];
  logic [15:0] rx;
  int          rx_bits;
  int          done_cnt;
  int          cyc;
  int          last_done;
  bit          have_last;

  seg_scan_if sif();

  seg_scan_595 #(.SCLK_DIV(2), .DWELL(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_all(input logic [3:0] c);
    sif.bit_0 = c; sif.bit_1 = c; sif.bit_2 = c; sif.bit_3 = c;
    sif.bit_4 = c; sif.bit_5 = c; sif.bit_6 = c; sif.bit_7 = c;
  endtask

  task automatic push_exp(input logic [15:0] f, input logic [2:0] i);
    sb_t e;
    e.frame = f;
    e.idx   = i;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("frame_done_seen", 32'(done_cnt != start), 32'd1);
  endtask

  task automatic wait_bits(input int n);
    int t;
    t = 0;
    while (rx_bits < n && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("bits_reached", 32'(rx_bits >= n), 32'd1);
  endtask

  // Checks all outputs at reset values for n cycles while rst is low.
  task automatic hold_reset(input int n);
    rst = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("reset_outputs",
            32'({sif.ds, sif.shcp, sif.stcp, sif.frame_done, sif.digit_idx}), 32'd0);
    end
  endtask

  // Releases reset and measures the cycle of the first shcp rise.
  task automatic release_and_time();
    int n;
    rst = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (sif.shcp) break;
    end
    check("first_shcp_rise_cycle", 32'(n), 32'd3);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    logic shcp_q, stcp_q, done_q;
    int   stcp_w;
    sb_t  e;
    shcp_q = 1'b0; stcp_q = 1'b0; done_q = 1'b0; stcp_w = 0;
    rx = 16'd0; rx_bits = 0; done_cnt = 0; cyc = 0; last_done = 0; have_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sif.shcp === 1'b1 && !shcp_q) begin
        check("stcp_low_at_shift", 32'(sif.stcp), 32'd0);
        rx = {rx[14:0], sif.ds};
        rx_bits++;
      end
      if (stcp_q && sif.stcp !== 1'b1) check("stcp_width", 32'(stcp_w), 32'd2);
      if (sif.stcp === 1'b1) stcp_w = stcp_q ? stcp_w + 1 : 1;
      if (sif.stcp === 1'b1 && !stcp_q) begin
        check("bits_before_latch", 32'(rx_bits), 32'd16);
        check("shcp_low_at_latch", 32'(sif.shcp), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_latch", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("frame_content", 32'(rx), 32'(e.frame));
          check("digit_idx", 32'(sif.digit_idx), 32'(e.idx));
        end
        rx_bits = 0;
      end
      if (done_q) check("frame_done_width", 32'(sif.frame_done), 32'd0);
      if (sif.frame_done === 1'b1 && !done_q) begin
        check("frame_done_in_latch", 32'(sif.stcp), 32'd1);
        if (have_last) check("frame_period", 32'(cyc - last_done), 32'd1067);
        last_done = cyc;
        have_last = 1'b1;
        done_cnt++;
      end
      shcp_q = (sif.shcp === 1'b1);
      stcp_q = (sif.stcp === 1'b1);
      done_q = (sif.frame_done === 1'b1);
    end
  end

  initial begin
    vec_t tbl[17];
    errors = 0;
    checks = 0;
    tbl[0]  = '{4'd5,  16'h9201};
    tbl[1]  = '{4'd10, 16'hFF02};
    tbl[2]  = '{4'd0,  16'hC004};
    tbl[3]  = '{4'd14, 16'hFF08};
    tbl[4]  = '{4'd1,  16'hF910};
    tbl[5]  = '{4'd11, 16'hBF20};
    tbl[6]  = '{4'd2,  16'hA440};
    tbl[7]  = '{4'd3,  16'hB080};
    tbl[8]  = '{4'd4,  16'h9901};
    tbl[9]  = '{4'd6,  16'h8202};
    tbl[10] = '{4'd7,  16'hF804};
    tbl[11] = '{4'd8,  16'h8008};
    tbl[12] = '{4'd9,  16'h9010};
    tbl[13] = '{4'd12, 16'hFF20};
    tbl[14] = '{4'd15, 16'hFF40};
    tbl[15] = '{4'd13, 16'hFF80};
    tbl[16] = '{4'd0,  16'hC001};

    set_all(4'd10);
    hold_reset(5);
    set_all(tbl[0].code);
    release_and_time();

    // Table frames: 17 consecutive frames cover every code and wrap 7 -> 0 twice.
    for (int i = 0; i < 17; i++) begin
      push_exp(tbl[i].exp, 3'(i % 8));
      wait_done();
      if (i < 16) set_all(tbl[i + 1].code);
    end

    set_all(4'd10);
    push_exp(16'hFF02, 3'd1);
    wait_done();

    // Input change mid-frame must not reach the frame in flight.
    set_all(4'd3);
    push_exp(16'hB004, 3'd2);
    wait_bits(7);
    sif.bit_2 = 4'd8;
    wait_done();

    // Reset during the high phase of frame bit 9 aborts the frame with no latch.
    set_all(4'd10);
    push_exp(16'hFF08, 3'd3);
    wait_bits(7);
    sb_q.delete();
    have_last = 1'b0;
    rx_bits = 0;
    hold_reset(3);
    set_all(4'd7);
    release_and_time();
    push_exp(16'hF801, 3'd0);
    wait_done();
    set_all(4'd9);
    push_exp(16'h9002, 3'd1);
    wait_done();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
